dma_ci_sequencer: RTL and testbench
===================================

DMA_CI_SEQUENCER -- requirements
Module: dma_ci_sequencer

Interface
REQ-001 Parameter customId, default 8'h00: CI number of the target DMA custom instruction; driven on ciN.
REQ-002 Parameter fifoDepthLog2, default 2: descriptor queue depth is 2**fifoDepthLog2.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 pushValid/pushReady  input/output  1/1  descriptor push handshake; transfer when both are high.
REQ-006 pushBusAddr  input  32  bus start address.
REQ-007 pushMemAddr  input  9  SRAM start word.
REQ-008 pushBlockSize  input  10  word count.
REQ-009 pushBurstSize  input  8  burst length minus 1.
REQ-010 pushDirIn  input  1  1 = bus->SRAM, 0 = SRAM->bus.
REQ-011 ciStart, ciN, ciValueA, ciValueB  output  1/8/32/32  CI master port.
REQ-012 ciDone, ciResult  input  1/32  CI completion and read data.
REQ-013 jobDone, jobError  output  1/1  one-cycle completion pulse and its error flag.
REQ-014 busy, queueCount  output  1/fifoDepthLog2+1  FSM not IDLE; queued descriptors.

Function
REQ-015 The queue SHALL be a FIFO, not a bypass path: pushReady = not full, independent of a same-cycle pop.
REQ-016 States SHALL be IDLE, POP, WR_BUS, WR_MEM, WR_SIZE, WR_BURST, WR_START, POLL, POLL_WAIT, COMPLETE.
REQ-017 IDLE->POP SHALL occur when the queue is non-empty.
REQ-018 POP SHALL latch the head descriptor into working registers and dequeue it. Next state is WR_BUS, or COMPLETE with error 0 if blockSize == 0.
REQ-019 WR_BUS, WR_MEM, WR_SIZE, WR_BURST and WR_START SHALL drive ciStart=1 with these values:
- WR_BUS: ciValueA=0x00000C00, ciValueB=busAddr.
- WR_MEM: ciValueA=0x00001400, ciValueB=memAddr.
- WR_SIZE: ciValueA=0x00001C00, ciValueB=blockSize.
- WR_BURST: ciValueA=0x00002400, ciValueB=burstSize.
- WR_START: ciValueA=0x00002C00, ciValueB=1 (dirIn) or 2.
REQ-020 Each WR state SHALL advance in the order listed on a cycle with ciDone=1, and SHALL otherwise hold with ciStart re-asserted.
REQ-021 After WR_START, the FSM SHALL enter POLL no earlier than the following cycle.
REQ-022 POLL SHALL assert ciStart for exactly one cycle with ciValueA=0x00002800 and ciValueB=0, then enter POLL_WAIT.
REQ-023 POLL_WAIT SHALL hold ciStart=0 until ciDone=1, then sample ciResult[1:0].
REQ-024 After sampling, if ciResult[0]=1 (busy) the FSM SHALL return to POLL; otherwise it enters COMPLETE with error = ciResult[1].
REQ-025 COMPLETE SHALL pulse jobDone for one cycle with jobError valid, then go to IDLE.
REQ-026 Outside active CI states, ciStart, ciValueA and ciValueB SHALL be 0; ciN SHALL always equal customId.
REQ-027 queueCount SHALL update on the cycle after push/pop; a simultaneous push and pop SHALL leave it unchanged.

Reset
REQ-028 With reset=0 at a clock edge, the block SHALL:
- go to IDLE and empty the queue;
- set pushReady=1 on the next cycle;
- drive ciStart, jobDone, jobError and busy to 0, including when reset arrives mid-job.

Configuration
REQ-029 With DMA_SEQ_ERROR_FLUSH_EN defined, COMPLETE with error=1 SHALL also flush all queued descriptors in the same cycle; without it, queued jobs proceed normally.

Structure
REQ-030 A shared package SHALL hold the state encoding, the CI opcode constants (0x0C00, 0x1400, 0x1C00, 0x2400, 0x2C00, 0x2800) and the descriptor field widths.
REQ-031 The descriptor queue SHALL be one sub-module, dma_desc_fifo, with parameter depthLog2.

Verification
REQ-032 Bench SHALL cover: push {0x80000000, 0x010, 16, 7, in}, target busy for 3 polls -> five CI writes in order, then 4 POLLs, then jobDone=1 with jobError=0.
REQ-033 Bench SHALL cover: push with blockSize=0 -> no ciStart at all, then jobDone=1 with jobError=0, two cycles after POP.
REQ-034 Bench SHALL cover: fill 4 descriptors while the FSM is stalled -> pushReady=0, queueCount=4; jobs then complete in FIFO order.
REQ-035 Bench SHALL cover: status returns 0x2 -> jobError=1. With DMA_SEQ_ERROR_FLUSH_EN, queueCount=0 afterwards; without it, the next job starts.
REQ-036 Bench SHALL cover: reset asserted during POLL_WAIT -> next cycle busy=0, ciStart=0, queueCount=0.
REQ-037 Bench SHALL cover: ciDone delayed 3 cycles in WR_MEM -> state holds, ciValueA stays 0x1400, and no state is skipped.

Source files
------------

// File: rtl/dma_ci_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | dma_ci_sequencer_pkg: shared state encoding, CI opcodes, descriptor layout |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package dma_ci_sequencer_pkg;

  localparam int BUS_ADDR_W   = 32;
  localparam int MEM_ADDR_W   = 9;
  localparam int BLOCK_SIZE_W = 10;
  localparam int BURST_SIZE_W = 8;

  localparam logic [31:0] CI_OP_BUS   = 32'h0000_0C00;
  localparam logic [31:0] CI_OP_MEM   = 32'h0000_1400;
  localparam logic [31:0] CI_OP_SIZE  = 32'h0000_1C00;
  localparam logic [31:0] CI_OP_BURST = 32'h0000_2400;
  localparam logic [31:0] CI_OP_START = 32'h0000_2C00;
  localparam logic [31:0] CI_OP_POLL  = 32'h0000_2800;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_POP       = 4'd1,
    ST_WR_BUS    = 4'd2,
    ST_WR_MEM    = 4'd3,
    ST_WR_SIZE   = 4'd4,
    ST_WR_BURST  = 4'd5,
    ST_WR_START  = 4'd6,
    ST_POLL      = 4'd7,
    ST_POLL_WAIT = 4'd8,
    ST_COMPLETE  = 4'd9
  } state_t;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0]   busAddr;
    logic [MEM_ADDR_W-1:0]   memAddr;
    logic [BLOCK_SIZE_W-1:0] blockSize;
    logic [BURST_SIZE_W-1:0] burstSize;
    logic                    dirIn;
  } desc_t;

  function automatic logic is_ci_state(input state_t s);
    return (s inside {ST_WR_BUS, ST_WR_MEM, ST_WR_SIZE, ST_WR_BURST, ST_WR_START, ST_POLL});
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_ci_sequencer_fifo.sv
// +----------------------------------------------------------------------------+
// | dma_desc_fifo: descriptor FIFO, 2**depthLog2 entries, synchronous flush    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dma_desc_fifo
  import dma_ci_sequencer_pkg::*;
#(
  parameter int depthLog2 = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  desc_t              pushData_i,
  output logic               ready_o,
  input  logic               pop_i,
  input  logic               flush_i,
  output desc_t              head_o,
  output logic [depthLog2:0] count_o
);

  localparam int                 ENTRIES   = 1 << depthLog2;
  localparam logic [depthLog2:0] FULL_CNT  = (depthLog2 + 1)'(ENTRIES);

  desc_t                mem_q [ENTRIES];
  logic [depthLog2-1:0] wrPtr_q;
  logic [depthLog2-1:0] rdPtr_q;
  logic [depthLog2:0]   count_q;
  logic                 doPush;
  logic                 doPop;

  // Readiness depends only on occupancy, never on a pop in the same cycle.
  assign ready_o = (count_q != FULL_CNT);
  assign doPush  = push_i && ready_o;
  assign doPop   = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      if (doPush && !doPop)      count_q <= count_q + 1'b1;
      else if (!doPush && doPop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/dma_ci_sequencer.sv
// +----------------------------------------------------------------------------+
// | dma_ci_sequencer: queues DMA descriptors and programs a DMA CI per job.    |
// | Option DMA_SEQ_ERROR_FLUSH_EN: an errored job also flushes the queue.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dma_ci_sequencer
  import dma_ci_sequencer_pkg::*;
#(
  parameter logic [7:0] customId      = 8'h00,
  parameter int         fifoDepthLog2 = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pushValid,
  output logic                   pushReady,
  input  logic [31:0]            pushBusAddr,
  input  logic [8:0]             pushMemAddr,
  input  logic [9:0]             pushBlockSize,
  input  logic [7:0]             pushBurstSize,
  input  logic                   pushDirIn,
  output logic                   ciStart,
  output logic [7:0]             ciN,
  output logic [31:0]            ciValueA,
  output logic [31:0]            ciValueB,
  input  logic                   ciDone,
  input  logic [31:0]            ciResult,
  output logic                   jobDone,
  output logic                   jobError,
  output logic                   busy,
  output logic [fifoDepthLog2:0] queueCount
);

  desc_t       pushDesc;
  desc_t       head;
  desc_t       job_q, job_d;
  state_t      state_q, state_d;
  logic        err_q, err_d;
  logic        popFifo;
  logic        flushFifo;
  logic [31:0] valA_d, valB_d;
  logic        ciStart_q, jobDone_q, jobError_q, busy_q;
  logic [31:0] ciValueA_q, ciValueB_q;
  logic        unusedResult;

  assign pushDesc = '{busAddr:   pushBusAddr,
                      memAddr:   pushMemAddr,
                      blockSize: pushBlockSize,
                      burstSize: pushBurstSize,
                      dirIn:     pushDirIn};

  assign popFifo      = (state_q == ST_POP);
  assign unusedResult = ^ciResult[31:2];

`ifdef DMA_SEQ_ERROR_FLUSH_EN
  assign flushFifo = (state_q == ST_COMPLETE) && err_q;
`else
  assign flushFifo = 1'b0;
`endif

  dma_desc_fifo #(
    .depthLog2 (fifoDepthLog2)
  ) u_fifo (
    .clk_i      (clock),
    .rst_ni     (reset),
    .push_i     (pushValid),
    .pushData_i (pushDesc),
    .ready_o    (pushReady),
    .pop_i      (popFifo),
    .flush_i    (flushFifo),
    .head_o     (head),
    .count_o    (queueCount)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    job_d   = job_q;
    case (state_q)
      ST_IDLE:      if (queueCount != '0) state_d = ST_POP;
      ST_POP: begin
        job_d   = head;
        err_d   = 1'b0;
        state_d = (head.blockSize == '0) ? ST_COMPLETE : ST_WR_BUS;
      end
      ST_WR_BUS:    if (ciDone) state_d = ST_WR_MEM;
      ST_WR_MEM:    if (ciDone) state_d = ST_WR_SIZE;
      ST_WR_SIZE:   if (ciDone) state_d = ST_WR_BURST;
      ST_WR_BURST:  if (ciDone) state_d = ST_WR_START;
      ST_WR_START:  if (ciDone) state_d = ST_POLL;
      ST_POLL:      state_d = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (ciDone) begin
          if (ciResult[0]) begin
            state_d = ST_POLL;
          end else begin
            state_d = ST_COMPLETE;
            err_d   = ciResult[1];
          end
        end
      end
      ST_COMPLETE:  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    valA_d = '0;
    valB_d = '0;
    case (state_d)
      ST_WR_BUS: begin
        valA_d = CI_OP_BUS;
        valB_d = job_d.busAddr;
      end
      ST_WR_MEM: begin
        valA_d = CI_OP_MEM;
        valB_d = 32'(job_d.memAddr);
      end
      ST_WR_SIZE: begin
        valA_d = CI_OP_SIZE;
        valB_d = 32'(job_d.blockSize);
      end
      ST_WR_BURST: begin
        valA_d = CI_OP_BURST;
        valB_d = 32'(job_d.burstSize);
      end
      ST_WR_START: begin
        valA_d = CI_OP_START;
        valB_d = job_d.dirIn ? 32'd1 : 32'd2;
      end
      ST_POLL: begin
        valA_d = CI_OP_POLL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      err_q      <= 1'b0;
      job_q      <= '0;
      ciStart_q  <= 1'b0;
      ciValueA_q <= '0;
      ciValueB_q <= '0;
      jobDone_q  <= 1'b0;
      jobError_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      job_q      <= job_d;
      ciStart_q  <= is_ci_state(state_d);
      ciValueA_q <= valA_d;
      ciValueB_q <= valB_d;
      jobDone_q  <= (state_d == ST_COMPLETE);
      jobError_q <= (state_d == ST_COMPLETE) && err_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign ciStart  = ciStart_q;
  assign ciN      = customId;
  assign ciValueA = ciValueA_q;
  assign ciValueB = ciValueB_q;
  assign jobDone  = jobDone_q;
  assign jobError = jobError_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_ci_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_dma_ci_sequencer: scoreboard bench with a CI slave model.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dma_ci_sequencer;

  localparam logic [7:0] CUST_ID = 8'hA5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pushValid = 1'b0;
  logic        pushReady;
  logic [31:0] pushBusAddr = '0;
  logic [8:0]  pushMemAddr = '0;
  logic [9:0]  pushBlockSize = '0;
  logic [7:0]  pushBurstSize = '0;
  logic        pushDirIn = 1'b0;
  logic        ciStart;
  logic [7:0]  ciN;
  logic [31:0] ciValueA, ciValueB;
  logic        ciDone = 1'b0;
  logic [31:0] ciResult = '0;
  logic        jobDone, jobError, busy;
  logic [2:0]  queueCount;

  dma_ci_sequencer #(
    .customId      (CUST_ID),
    .fifoDepthLog2 (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pushValid     (pushValid),
    .pushReady     (pushReady),
    .pushBusAddr   (pushBusAddr),
    .pushMemAddr   (pushMemAddr),
    .pushBlockSize (pushBlockSize),
    .pushBurstSize (pushBurstSize),
    .pushDirIn     (pushDirIn),
    .ciStart       (ciStart),
    .ciN           (ciN),
    .ciValueA      (ciValueA),
    .ciValueB      (ciValueB),
    .ciDone        (ciDone),
    .ciResult      (ciResult),
    .jobDone       (jobDone),
    .jobError      (jobError),
    .busy          (busy),
    .queueCount    (queueCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } ci_op_t;

  ci_op_t     expCi[$];
  logic       expJob[$];
  logic [1:0] statusScript[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: a job is five register writes, then one poll per busy
  // status plus the final poll, then a completion carrying status bit 1.
  task automatic model_job(input logic [31:0] bus, input logic [8:0] mem, input logic [9:0] size,
                           input logic [7:0] burst, input logic dirIn, input int nBusy, input logic err);
    if (size == 10'd0) begin
      expJob.push_back(1'b0);
    end else begin
      expCi.push_back('{32'h0000_0C00, bus});
      expCi.push_back('{32'h0000_1400, {23'd0, mem}});
      expCi.push_back('{32'h0000_1C00, {22'd0, size}});
      expCi.push_back('{32'h0000_2400, {24'd0, burst}});
      expCi.push_back('{32'h0000_2C00, dirIn ? 32'd1 : 32'd2});
      for (int i = 0; i <= nBusy; i++) expCi.push_back('{32'h0000_2800, 32'd0});
      for (int i = 0; i < nBusy; i++) statusScript.push_back(2'b01);
      statusScript.push_back(err ? 2'b10 : 2'b00);
      expJob.push_back(err);
    end
  endtask

  task automatic push_desc(input logic [31:0] bus, input logic [8:0] mem, input logic [9:0] size,
                           input logic [7:0] burst, input logic dirIn, input int nBusy,
                           input logic err, input logic modelIt);
    int guard = 0;
    while (pushReady !== 1'b1 && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 5000) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got pushReady=%0b required 1", pushReady);
    end else begin
      pushBusAddr = bus; pushMemAddr = mem; pushBlockSize = size;
      pushBurstSize = burst; pushDirIn = dirIn; pushValid = 1'b1;
      @(negedge clock);
      pushValid = 1'b0;
      if (modelIt) model_job(bus, mem, size, burst, dirIn, nBusy, err);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((expJob.size() != 0 || busy === 1'b1) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain_jobs_left", expJob.size(), 0);
    check("drain_ci_left", expCi.size(), 0);
  endtask

  // CI slave and monitor: answers transactions, pops the scoreboard on each
  // new ciStart and on each jobDone.
  logic        slaveBusy = 1'b0;
  logic        slaveHold = 1'b0;
  logic        slaveHoldPoll = 1'b0;
  logic        sawPoll = 1'b0;
  int          slaveWait = 0;
  int          forceMemDelay = -1;
  logic [31:0] curA = '0, curB = '0;
  logic [1:0]  curStatus = '0;
  ci_op_t      eOp;
  logic        eJob;

  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      slaveBusy = 1'b0;
      ciDone    = 1'b0;
      ciResult  = '0;
    end else begin
      if (slaveBusy) begin
        if (curA == 32'h0000_2800) begin
          check("poll_wait_start_low", ciStart, 0);
        end else begin
          check("wr_hold_start", ciStart, 1);
          check("wr_hold_a", ciValueA, curA);
          check("wr_hold_b", ciValueB, curB);
        end
        if (slaveHold || (slaveHoldPoll && curA == 32'h0000_2800)) begin
          ciDone = 1'b0;
        end else if (slaveWait == 0) begin
          ciDone    = 1'b1;
          ciResult  = (curA == 32'h0000_2800) ? {30'd0, curStatus} : $urandom;
          slaveBusy = 1'b0;
        end else begin
          slaveWait--;
        end
      end else begin
        ciDone   = 1'b0;
        ciResult = '0;
        if (ciStart === 1'b1) begin
          if (expCi.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ci_start: got A=%0h B=%0h required no transaction", ciValueA, ciValueB);
          end else begin
            eOp = expCi.pop_front();
            check("ci_value_a", ciValueA, eOp.a);
            check("ci_value_b", ciValueB, eOp.b);
          end
          curA      = ciValueA;
          curB      = ciValueB;
          slaveBusy = 1'b1;
          slaveWait = (curA == 32'h0000_1400 && forceMemDelay >= 0) ? forceMemDelay : $urandom_range(0, 3);
          if (curA == 32'h0000_2800) begin
            sawPoll   = 1'b1;
            curStatus = (statusScript.size() != 0) ? statusScript.pop_front() : 2'b00;
          end
        end else begin
          check("idle_value_a", ciValueA, 0);
          check("idle_value_b", ciValueB, 0);
        end
      end
      if (jobDone === 1'b1) begin
        if (expJob.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_job_done: got jobDone=1 required 0");
        end else begin
          eJob = expJob.pop_front();
          check("job_error", jobError, eJob);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [9:0] sz;
    logic       er;

    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_push_ready", pushReady, 1);
    check("rst_ci_start", ciStart, 0);
    check("rst_job_done", jobDone, 0);
    check("rst_job_error", jobError, 0);
    check("rst_queue_count", queueCount, 0);
    check("ci_n", ciN, CUST_ID);
    reset = 1'b1;
    @(negedge clock);

    // Nominal inbound job, target busy for three polls
    push_desc(32'h8000_0000, 9'h010, 10'd16, 8'd7, 1'b1, 3, 1'b0, 1'b1);
    wait_drain(2000);

    // Zero-length job completes without touching the CI
    push_desc(32'h1234_5678, 9'h1FF, 10'd0, 8'd3, 1'b0, 0, 1'b0, 1'b1);
    n = 0;
    while (jobDone !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("zero_size_latency", n, 2);
    wait_drain(100);

    // Slow completion of the memory-address write
    forceMemDelay = 3;
    push_desc(32'hCAFE_0000, 9'h005, 10'd4, 8'd0, 1'b0, 0, 1'b0, 1'b1);
    wait_drain(500);
    forceMemDelay = -1;

    // Fill the queue while the FSM is stalled on a write
    slaveHold = 1'b1;
    push_desc(32'h0000_A000, 9'h001, 10'd8, 8'd1, 1'b1, 0, 1'b0, 1'b1);
    n = 0;
    while (slaveBusy !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("stall_reached", slaveBusy, 1);
    for (int i = 0; i < 4; i++)
      push_desc(32'h1000_0000 + i, 9'(i * 3), 10'(i + 1), 8'(i), i[0], i % 2, 1'b0, 1'b1);
    check("full_push_ready", pushReady, 0);
    check("full_queue_count", queueCount, 4);
    slaveHold = 1'b0;
    wait_drain(3000);

    // Error status, with one job queued behind it
    slaveHold = 1'b1;
    push_desc(32'hBAD0_0000, 9'h020, 10'd2, 8'd0, 1'b0, 1, 1'b1, 1'b1);
    n = 0;
    while (slaveBusy !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
`ifdef DMA_SEQ_ERROR_FLUSH_EN
    push_desc(32'h0000_0BAD, 9'h021, 10'd3, 8'd1, 1'b1, 0, 1'b0, 1'b0);
`else
    push_desc(32'h0000_0BAD, 9'h021, 10'd3, 8'd1, 1'b1, 0, 1'b0, 1'b1);
`endif
    slaveHold = 1'b0;
    n = 0;
    while (jobDone !== 1'b1 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("error_job_done", jobDone, 1);
    check("error_job_flag", jobError, 1);
    @(negedge clock);
`ifdef DMA_SEQ_ERROR_FLUSH_EN
    check("after_error_queue", queueCount, 0);
`else
    check("after_error_queue", queueCount, 1);
`endif
    wait_drain(1000);

    // Reset while waiting on a poll response
    slaveHoldPoll = 1'b1;
    sawPoll = 1'b0;
    push_desc(32'h5555_0000, 9'h055, 10'd5, 8'd5, 1'b1, 0, 1'b0, 1'b1);
    n = 0;
    while (sawPoll !== 1'b1 && n < 500) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    push_desc(32'h6666_0000, 9'h066, 10'd6, 8'd6, 1'b0, 0, 1'b0, 1'b0);
    check("pre_reset_busy", busy, 1);
    reset = 1'b0;
    @(negedge clock);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_ci_start", ciStart, 0);
    check("mid_reset_queue_count", queueCount, 0);
    check("mid_reset_job_done", jobDone, 0);
    check("mid_reset_push_ready", pushReady, 1);
    expCi.delete();
    expJob.delete();
    statusScript.delete();
    slaveHoldPoll = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    // Randomised jobs
    for (int j = 0; j < 20; j++) begin
      sz = ($urandom_range(0, 4) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
`ifdef DMA_SEQ_ERROR_FLUSH_EN
      er = 1'b0;
`else
      er = 1'($urandom_range(0, 1));
`endif
      push_desc($urandom, 9'($urandom), sz, 8'($urandom), 1'($urandom), $urandom_range(0, 2), er, 1'b1);
      repeat ($urandom_range(0, 6)) @(negedge clock);
    end
    wait_drain(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
